delay_event_scheduler: RTL and testbench

DELAY_EVENT_SCHEDULER -- requirements
Module: delay_event_scheduler

---
 rtl/dly_sched_pkg.sv | 42 ++++
 rtl/dly_evt_fifo.sv | 75 +++++++
 rtl/delay_event_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_delay_event_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dly_sched_pkg.sv
// dly_sched_pkg: shared types for the delay event scheduler.
// Holds the mode and FSM state enums, the transport queue entry and
// small helper functions used by delay_event_scheduler and dly_evt_fifo.
package dly_sched_pkg;

    // Width of the stored due field; the scheduler uses the low DELAY_W+1 bits.
    localparam int unsigned DUE_W = 16;

    typedef enum logic [1:0] {
        MODE_SAMPLE_LATE  = 2'd0,
        MODE_SAMPLE_EARLY = 2'd1,
        MODE_TRANSPORT    = 2'd2,
        MODE_RESERVED     = 2'd3
    } dly_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dly_state_e;

    typedef struct packed {
        logic             value;
        logic [DUE_W-1:0] due;
    } dly_evt_t;

    // The reserved encoding is treated as a transport request.
    function automatic logic is_transport(input dly_mode_e m);
        return (m == MODE_TRANSPORT) || (m == MODE_RESERVED);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dly_evt_fifo.sv
// dly_evt_fifo: synchronous FIFO of scheduled events.
// A push while full is accepted only when a pop happens in the same cycle,
// so the slot freed by the pop is reused immediately.
module dly_evt_fifo
    import dly_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  dly_evt_t               push_data,
    input  logic                   pop,
    output dly_evt_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    dly_evt_t      mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          do_push_s;
    logic          do_pop_s;

    // Occupancy flags and qualified push/pop strobes
    always_comb begin
        full_s    = (count_r == (AW+1)'(DEPTH));
        empty_s   = (count_r == {(AW+1){1'b0}});
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Read/write pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, cleared on reset so no stale data survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{value: 1'b0, due: {DUE_W{1'b0}}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/delay_event_scheduler.sv
// delay_event_scheduler: produces q, a delayed replica of b.
// SAMPLE_LATE / SAMPLE_EARLY use a single-shot timer FSM; TRANSPORT queues
// every edge of b with its own due time in dly_evt_fifo.
// Optional build macro DLY_SCHED_STATS_EN adds the saturating drop_cnt output.
module delay_event_scheduler
    import dly_sched_pkg::*;
#(
    parameter int DELAY_W = 4,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   b,
    input  logic [DELAY_W-1:0]     delay,
    input  logic [1:0]             mode,
    output logic                   q,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
`ifdef DLY_SCHED_STATS_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);
    localparam int TS_W  = DELAY_W + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Due times live in the low TS_W bits; lag below half the wheel means "reached".
    localparam logic [DUE_W-1:0] TS_MASK  = DUE_W'((32'd1 << TS_W) - 32'd1);
    localparam logic [DUE_W-1:0] HALF_TS  = DUE_W'(32'd1 << DELAY_W);

    logic               b_d_r;
    logic [TS_W-1:0]    ts_r;
    dly_mode_e          mode_r;
    dly_state_e         state_r;
    dly_state_e         state_s;
    logic [DELAY_W-1:0] timer_r;
    logic [DELAY_W-1:0] timer_s;
    logic               cap_r;
    logic               cap_s;
    logic               q_r;
    logic               q_s;
    logic               ovf_r;

    logic               evt_s;
    logic [DELAY_W-1:0] d_eff_s;
    logic               busy_s;
    dly_mode_e          eff_mode_s;
    logic               transport_s;

    dly_evt_t           push_data_s;
    dly_evt_t           head_s;
    logic [DUE_W-1:0]   lag_s;
    logic               push_req_s;
    logic               push_s;
    logic               pop_s;
    logic               q_drop_s;
    logic               full_s;
    logic               empty_s;
    logic [CNT_W-1:0]   fifo_cnt_s;

    // Edge detection, effective delay and the mode in force this cycle
    always_comb begin
        evt_s       = b ^ b_d_r;
        d_eff_s     = (delay == {DELAY_W{1'b0}}) ? DELAY_W'(1'b1) : delay;
        busy_s      = (state_r == ST_WAIT) || (fifo_cnt_s != {CNT_W{1'b0}});
        eff_mode_s  = busy_s ? mode_r : dly_mode_e'(mode);
        transport_s = is_transport(eff_mode_s);
    end

    // Transport queue control: due stamping, head readiness, push/drop decision
    always_comb begin
        push_data_s.value = b;
        push_data_s.due   = DUE_W'(ts_r + TS_W'(d_eff_s));
        lag_s             = (DUE_W'(ts_r) - head_s.due) & TS_MASK;
        pop_s             = !empty_s && (lag_s < HALF_TS);
        push_req_s        = evt_s && transport_s;
        push_s            = push_req_s && (!full_s || pop_s);
        q_drop_s          = push_req_s && full_s && !pop_s;
    end

    // Sample-mode FSM next state and output value selection
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        cap_s   = cap_r;
        q_s     = q_r;
        case (state_r)
            ST_IDLE: begin
                if (evt_s && !transport_s) begin
                    state_s = ST_WAIT;
                    timer_s = d_eff_s;
                    cap_s   = b;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (timer_r == DELAY_W'(1'b1)) begin
                    state_s = ST_IDLE;
                    timer_s = {DELAY_W{1'b0}};
                    q_s     = (mode_r == MODE_SAMPLE_EARLY) ? cap_r : b;
                end else begin
                    timer_s = timer_r - DELAY_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = {DELAY_W{1'b0}};
            end
        endcase
        if (pop_s) begin
            q_s = head_s.value;
        end else begin
            q_s = q_s;
        end
    end

    // Input history, free-running timestamp, latched mode and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_d_r  <= 1'b0;
            ts_r   <= {TS_W{1'b0}};
            mode_r <= MODE_SAMPLE_LATE;
            ovf_r  <= 1'b0;
        end else begin
            b_d_r  <= b;
            ts_r   <= ts_r + TS_W'(1'b1);
            mode_r <= eff_mode_s;
            ovf_r  <= ovf_r | q_drop_s;
        end
    end

    // FSM state, wait timer, captured value and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= {DELAY_W{1'b0}};
            cap_r   <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            cap_r   <= cap_s;
            q_r     <= q_s;
        end
    end

    dly_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_cnt_s)
    );

`ifdef DLY_SCHED_STATS_EN
    logic        samp_drop_s;
    logic [15:0] drop_cnt_r;

    // Every edge seen while waiting (including the expiry cycle) is lost
    always_comb begin
        samp_drop_s = (state_r == ST_WAIT) && evt_s;
    end

    // Saturating count of ignored, lost and queue-dropped events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'd0;
        end else if (samp_drop_s || q_drop_s) begin
            drop_cnt_r <= sat_inc16(drop_cnt_r);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign q        = q_r;
    assign busy     = busy_s;
    assign count    = (state_r == ST_WAIT) ? CNT_W'(1'b1) : fifo_cnt_s;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_delay_event_scheduler.sv
// tb_delay_event_scheduler: table-driven scenarios, hand-written corner
// sequences and randomized stimulus against an event-list reference model.
module tb_delay_event_scheduler;
    import dly_sched_pkg::*;

    localparam int DELAY_W = 4;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               b;
    logic [DELAY_W-1:0] delay;
    logic [1:0]         mode;
    logic               q;
    logic               busy;
    logic [CNT_W-1:0]   count;
    logic               overflow;
`ifdef DLY_SCHED_STATS_EN
    logic [15:0]        drop_cnt;
`endif

    always #5 clk = ~clk;

    delay_event_scheduler #(.DELAY_W(DELAY_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .b        (b),
        .delay    (delay),
        .mode     (mode),
        .q        (q),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
`ifdef DLY_SCHED_STATS_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: absolute cycle numbers, unbounded due times.
    typedef struct { logic val; int due; } mev_t;
    mev_t mq[$];
    int   mk = 0;
    logic m_q, m_wait, m_cap, m_ovf, m_bprev;
    int   m_exp, m_mode_l, m_drops;

    // Scenario observation
    int   s_rel, s_chg, s_first, s_peak;
    logic s_prevq;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_q = 1'b0; m_wait = 1'b0; m_cap = 1'b0; m_ovf = 1'b0; m_bprev = 1'b0;
        m_exp = 0; m_mode_l = 0; m_drops = 0;
    endtask

    task automatic model_step();
        int   d;
        logic ev;
        mev_t e;
        d  = (delay == 0) ? 1 : int'(delay);
        ev = (b != m_bprev);
        if (!(m_wait || mq.size() != 0)) m_mode_l = int'(mode);
        if (m_mode_l >= 2) begin
            if (mq.size() != 0 && mq[0].due <= mk) begin
                m_q = mq[0].val;
                void'(mq.pop_front());
            end
            if (ev) begin
                if (mq.size() < DEPTH) begin
                    e.val = b; e.due = mk + d;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end else if (m_wait) begin
            if (mk == m_exp) begin
                m_q = (m_mode_l == 1) ? m_cap : b;
                m_wait = 1'b0;
            end
            if (ev && m_drops < 65535) m_drops++;
        end else if (ev) begin
            m_wait = 1'b1; m_exp = mk + d; m_cap = b;
        end
        m_bprev = b;
        mk++;
    endtask

    task automatic start_obs();
        s_rel = 0; s_chg = 0; s_first = -1; s_peak = 0; s_prevq = q;
    endtask

    // One clock: DUT and model advance together, outputs compared after the edge.
    task automatic step();
        logic eb;
        int   ec;
        @(posedge clk);
        model_step();
        #1;
        eb = m_wait || (mq.size() != 0);
        ec = m_wait ? 1 : mq.size();
        total++;
        if (q !== m_q || busy !== eb || overflow !== m_ovf || int'(count) != ec) begin
            bad++;
            $display("FAIL model cyc=%0d: got q=%b busy=%b cnt=%0d ovf=%b expected q=%b busy=%b cnt=%0d ovf=%b",
                     mk, q, busy, count, overflow, m_q, eb, ec, m_ovf);
        end
`ifdef DLY_SCHED_STATS_EN
        check("model_drop_cnt", int'(drop_cnt), m_drops);
`endif
        if (q !== s_prevq) begin
            s_chg++;
            if (s_first < 0) s_first = s_rel;
        end
        s_prevq = q;
        if (int'(count) > s_peak) s_peak = int'(count);
        s_rel++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_outputs", int'({q, busy, overflow, count}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int mode; int dly; int chg; int first; int fin; int peak; int drops;
    } row_t;
    row_t tab[6];

    // b: 0->1 at rel 0, 1->0 at rel 2, 0->1 at rel 3.
    task automatic run_row(input row_t r);
        do_reset();
        mode = 2'(r.mode); delay = DELAY_W'(r.dly); b = 1'b0;
        step(); step();
        start_obs();
        for (int i = 0; i < 40; i++) begin
            b = (i == 2) ? 1'b0 : 1'b1;
            step();
        end
        check("row_changes", s_chg, r.chg);
        check("row_first_edge", s_first, r.first);
        check("row_final_q", int'(q), r.fin);
        check("row_peak_count", s_peak, r.peak);
        check("row_overflow", int'(overflow), 0);
`ifdef DLY_SCHED_STATS_EN
        check("row_drop_cnt", int'(drop_cnt), r.drops);
`endif
    endtask

    initial begin
        rst_n = 1'b1; b = 1'b0; delay = '0; mode = 2'd0;
        #2;

        tab[0] = '{0, 12, 1, 12, 1, 1, 2};
        tab[1] = '{1, 12, 1, 12, 1, 1, 2};
        tab[2] = '{2, 12, 3, 12, 1, 3, 0};
        tab[3] = '{0,  0, 1,  1, 1, 1, 1};
        tab[4] = '{1,  0, 2,  1, 0, 1, 1};
        tab[5] = '{3,  0, 3,  1, 1, 1, 0};
        for (int i = 0; i < 6; i++) run_row(tab[i]);

        // Queue overflow: 10 back-to-back edges with delay 15 into 8 slots.
        do_reset();
        mode = 2'd2; delay = 4'd15; b = 1'b0;
        step(); step();
        start_obs();
        for (int i = 0; i < 10; i++) begin
            b = ~b;
            step();
            check("ovf_after_evt", int'(overflow), (i >= 8) ? 1 : 0);
            if (i == 7) check("ovf_full_count", int'(count), 8);
        end
        for (int i = 0; i < 20; i++) step();
        check("ovf_replay_changes", s_chg, 8);
        check("ovf_replay_first", s_first, 15);
        check("ovf_sticky", int'(overflow), 1);

        // Reset while two events are queued.
        do_reset();
        mode = 2'd2; delay = 4'd3; b = 1'b0;
        step(); step();
        b = 1'b1; step();
        b = 1'b0; step();
        check("rst_pre_count", int'(count), 2);
        do_reset();
        start_obs();
        for (int i = 0; i < 10; i++) step();
        check("rst_no_edges", s_chg, 0);
        start_obs();
        b = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("rst_first_after", s_first, 3);

        // delay 0 transport, toggling every cycle across timestamp wrap.
        do_reset();
        mode = 2'd2; delay = 4'd0; b = 1'b0;
        step();
        start_obs();
        for (int i = 0; i < 71; i++) begin
            if (i < 70) b = ~b;
            step();
        end
        check("wrap_changes", s_chg, 70);
        check("wrap_first", s_first, 1);

        // Randomized stimulus against the model.
        do_reset();
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) < (((i / 100) % 2 == 1) ? 80 : 25)) b = ~b;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) delay = DELAY_W'($urandom_range(0, 15));
            if (i % 300 == 299) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
